udp_top_hls_deadlock_report_ctrl: RTL

Central controller that consumes the dl_detect_out pulses of all PROC_NUM per-process deadlock detect units in the UDP HLS top. It picks an origin process, broadcasts dl_detect_in, launches and terminates token circulation, and records the ordered list of process IDs on the deadlock cycle. Software and debug logic read that list through a trace read port.

---
 rtl/udp_top_hls_deadlock_report_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/udp_top_hls_deadlock_report_ctrl.sv
// ---------------------------------------------------------------------------
// udp_top_hls_deadlock_report_ctrl
//
// Central deadlock-report controller for the UDP HLS top. Watches the
// dl_detect_out pulses of all per-process detect units, picks an origin
// process, broadcasts dl_detect_in, then records the ordered list of
// process IDs visited by the circulating token until the cycle closes back
// on the origin (or the no-progress timer expires).
//
// Ports:
//   clock           - single clock, rising edge
//   reset           - asynchronous, active-low reset
//   dl_detect_vec   - bit i = dl_detect_out of detect unit i
//   dl_detect_bcast - dl_detect_in broadcast to every unit
//   origin_vec      - one-hot origin strobe, non-zero for one cycle only
//   token_clear     - broadcast token_clear, aligned with the closing detect
//   trace_done      - sticky: cycle closed or timed out
//   trace_timeout   - sticky: trace aborted by the no-progress timer
//   trace_overflow  - sticky: more hops seen than trace entries available
//   trace_count     - number of valid trace entries
//   trace_rd_addr   - trace read address
//   trace_rd_data   - registered trace read data (1-cycle latency)
// ---------------------------------------------------------------------------
module udp_top_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM    = 4,
  parameter int PROC_ID_W   = 2,
  parameter int TRACE_DEPTH = 8,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [PROC_NUM-1:0]            dl_detect_vec,
  output logic                           dl_detect_bcast,
  output logic [PROC_NUM-1:0]            origin_vec,
  output logic                           token_clear,
  output logic                           trace_done,
  output logic                           trace_timeout,
  output logic                           trace_overflow,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_addr,
  output logic [PROC_ID_W-1:0]           trace_rd_data
);

  localparam int CNT_W  = $clog2(TRACE_DEPTH) + 1;
  localparam int ADDR_W = $clog2(TRACE_DEPTH);
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(TRACE_DEPTH);
  localparam logic [PROC_NUM-1:0] ONE_HOT_0 = PROC_NUM'(1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ORIGIN  = 3'd1;
  localparam logic [2:0] TRACE   = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] TIMEOUT = 3'd4;

  logic [2:0]           state_reg, state_next;
  logic [PROC_ID_W-1:0] origin_reg, origin_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [TIMEOUT_W-1:0] timer_reg, timer_next;
  logic                 overflow_reg, overflow_next;
  logic [PROC_ID_W-1:0] rd_data_reg;

  logic                 any_detect;
  logic [PROC_ID_W-1:0] sel_idx;
  logic                 closing;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;

  logic [PROC_ID_W-1:0] trace_mem [TRACE_DEPTH];

  assign any_detect = |dl_detect_vec;

  // Lowest set bit wins: scan from the top so the lowest index is written last.
  always_comb begin
    sel_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_detect_vec[i]) sel_idx = PROC_ID_W'(i);
    end
  end

  // The cycle closes only when the *selected* index is the origin; an origin
  // bit masked by a lower set bit is treated as an ordinary hop.
  assign closing = (state_reg == TRACE) && any_detect && (sel_idx == origin_reg);

  always_comb begin
    state_next    = state_reg;
    origin_next   = origin_reg;
    count_next    = count_reg;
    timer_next    = timer_reg;
    overflow_next = overflow_reg;
    wr_en         = 1'b0;
    wr_addr       = '0;
    case (state_reg)
      IDLE: begin
        if (any_detect) begin
          origin_next = sel_idx;
          count_next  = CNT_W'(1);
          wr_en       = 1'b1;
          state_next  = ORIGIN;
        end
      end
      ORIGIN: begin
        timer_next = '0;
        state_next = TRACE;
      end
      TRACE: begin
        if (closing) begin
          state_next = DONE;
        end else if (any_detect) begin
          // Any hop counts as progress, even when it cannot be stored.
          timer_next = '0;
          if (count_reg < DEPTH_C) begin
            wr_en      = 1'b1;
            wr_addr    = count_reg[ADDR_W-1:0];
            count_next = count_reg + CNT_W'(1);
          end else begin
            overflow_next = 1'b1;
          end
        end else begin
          timer_next = timer_reg + TIMEOUT_W'(1);
          if (&timer_reg) state_next = TIMEOUT;
        end
      end
      default: ; // DONE / TIMEOUT hold until reset
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      origin_reg   <= '0;
      count_reg    <= '0;
      timer_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      origin_reg   <= origin_next;
      count_reg    <= count_next;
      timer_reg    <= timer_next;
      overflow_reg <= overflow_next;
    end
  end

  // Trace storage: plain array with registered read so it maps to block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) trace_mem[wr_addr] <= sel_idx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data_reg <= '0;
    else        rd_data_reg <= trace_mem[trace_rd_addr];
  end

  // Broadcast stays high from ORIGIN onward so DONE/TIMEOUT freeze the units.
  assign dl_detect_bcast = (state_reg != IDLE);
  assign origin_vec      = (state_reg == ORIGIN) ? (ONE_HOT_0 << origin_reg) : '0;
  assign token_clear     = closing;
  assign trace_done      = (state_reg == DONE) || (state_reg == TIMEOUT);
  assign trace_timeout   = (state_reg == TIMEOUT);
  assign trace_overflow  = overflow_reg;
  assign trace_count     = count_reg;
  assign trace_rd_data   = rd_data_reg;

endmodule
